consumer_pool: RTL and testbench

- Parametrised pool of N_LANES job consumers in the vecunit, fed through a small input FIFO.
- Each job carries its own service latency. A free lane takes the job, counts the latency down, then presents a completion record.
- Producers use a valid/ready input handshake; a downstream observer drains completions with valid/ready.
- busy/occupancy outputs replace the single-job busy flag of the previous generation.

---
 rtl/vecunit_pkg.sv | 29 ++
 rtl/consumer_pool_if.sv | 43 ++++
 rtl/consumer_pool_sync_fifo.sv | 58 +++++
 rtl/consumer_pool.sv | 165 ++++++++++++++++
 tb/tb_consumer_pool.sv | 407 ++++++++++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/vecunit_pkg.sv
`default_nettype none
// ============================================================================
// Module      : vecunit_pkg
// Description : Shared types and width helpers for the vecunit consumer pool.
// Revision    : 1.0 - initial release
// ============================================================================
package vecunit_pkg;

  localparam int C_JOB_W = 6;
  localparam int C_LAT_W = 4;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    DONE = 2'd2
  } lane_state_e;

  typedef struct packed {
    logic [C_JOB_W-1:0] job;
    logic [C_LAT_W-1:0] lat;
  } job_entry_t;

  // A single-lane pool still needs a 1-bit lane index.
  function automatic int lane_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage
`default_nettype wire

// File: rtl/consumer_pool_if.sv
`default_nettype none
// ============================================================================
// Module      : consumer_pool_if
// Description : Job input and completion output handshakes of the pool.
// Revision    : 1.0 - initial release
// ============================================================================
interface consumer_pool_if
  import vecunit_pkg::*;
#(
  parameter int JOB_W      = C_JOB_W,
  parameter int LAT_W      = C_LAT_W,
  parameter int N_LANES    = 2,
  parameter int FIFO_DEPTH = 4
);
  localparam int LANE_W = lane_w(N_LANES);
  localparam int CNT_W  = $clog2(FIFO_DEPTH) + 1;

  logic               job_valid_i;
  logic               job_ready_o;
  logic [JOB_W-1:0]   job_i;
  logic [LAT_W-1:0]   lat_i;
  logic               done_valid_o;
  logic               done_ready_i;
  logic [JOB_W-1:0]   done_job_o;
  logic [LANE_W-1:0]  done_lane_o;
  logic               busy_o;
  logic [N_LANES-1:0] lane_busy_o;
  logic [CNT_W-1:0]   fifo_count_o;

  modport slave (
    input  job_valid_i, job_i, lat_i, done_ready_i,
    output job_ready_o, done_valid_o, done_job_o, done_lane_o,
           busy_o, lane_busy_o, fifo_count_o
  );

  modport master (
    output job_valid_i, job_i, lat_i, done_ready_i,
    input  job_ready_o, done_valid_o, done_job_o, done_lane_o,
           busy_o, lane_busy_o, fifo_count_o
  );

endinterface
`default_nettype wire

// File: rtl/consumer_pool_sync_fifo.sv
`default_nettype none
// ============================================================================
// Module      : sync_fifo
// Description : Single-clock FIFO with full/empty flags and occupancy count.
// Revision    : 1.0 - initial release
// ============================================================================
module sync_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 4
) (
  input  wire logic                     clk_i,
  input  wire logic                     rst_ni,
  input  wire logic                     push_i,
  input  wire logic                     pop_i,
  input  wire logic [WIDTH-1:0]         wdata_i,
  output logic      [WIDTH-1:0]         rdata_o,
  output logic                          full_o,
  output logic                          empty_o,
  output logic      [$clog2(DEPTH):0]   count_o
);
  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [AW-1:0]    r_wr_ptr;
  logic [AW-1:0]    r_rd_ptr;
  logic [AW:0]      r_count;
  logic             w_push_ok;
  logic             w_pop_ok;

  assign full_o    = (r_count == (AW+1)'(DEPTH));
  assign empty_o   = (r_count == '0);
  assign count_o   = r_count;
  assign rdata_o   = r_mem[r_rd_ptr];
  assign w_push_ok = push_i & ~full_o;
  assign w_pop_ok  = pop_i & ~empty_o;

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_push_ok) r_wr_ptr <= r_wr_ptr + AW'(1);
      if (w_pop_ok)  r_rd_ptr <= r_rd_ptr + AW'(1);
      case ({w_push_ok, w_pop_ok})
        2'b10:   r_count <= r_count + (AW+1)'(1);
        2'b01:   r_count <= r_count - (AW+1)'(1);
        default: r_count <= r_count;
      endcase
    end
  end

  always_ff @(posedge clk_i) begin
    if (w_push_ok) r_mem[r_wr_ptr] <= wdata_i;
  end

endmodule
`default_nettype wire

// File: rtl/consumer_pool.sv
`default_nettype none
// ============================================================================
// Module      : consumer_pool
// Description : FIFO-fed pool of latency-counting lanes with a round-robin
//               completion arbiter.
// Revision    : 1.0 - initial release
// ============================================================================
module consumer_pool
  import vecunit_pkg::*;
#(
  parameter int JOB_W      = C_JOB_W,
  parameter int LAT_W      = C_LAT_W,
  parameter int N_LANES    = 2,
  parameter int FIFO_DEPTH = 4
) (
  input wire logic        clk_i,
  input wire logic        rst_ni,
  consumer_pool_if.slave  bus
);
  localparam int LANE_W = lane_w(N_LANES);
  localparam int CNT_W  = $clog2(FIFO_DEPTH) + 1;

  typedef struct packed {
    logic [JOB_W-1:0] job;
    logic [LAT_W-1:0] lat;
  } entry_t;

  entry_t             w_head;
  entry_t             w_wentry;
  logic               w_full;
  logic               w_empty;
  logic               w_push;
  logic               w_pop;
  logic [CNT_W-1:0]   w_count;
  logic [N_LANES-1:0] w_is_idle;
  logic [N_LANES-1:0] w_is_done;
  logic [JOB_W-1:0]   w_lane_job [N_LANES];
  logic [LANE_W-1:0]  w_disp_lane;
  logic               w_rr_valid;
  logic [LANE_W-1:0]  w_rr_sel;
  logic [LANE_W-1:0]  w_sel;
  logic               w_valid;
  logic               w_accept;
  logic [LANE_W-1:0]  r_ptr;
  logic [LANE_W-1:0]  r_lock_lane;
  logic               r_locked;

  assign w_wentry = '{job: bus.job_i, lat: bus.lat_i};
  assign w_push   = bus.job_valid_i & ~w_full;
  assign w_pop    = ~w_empty & (|w_is_idle);

  sync_fifo #(
    .WIDTH (JOB_W + LAT_W),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk_i   (clk_i),
    .rst_ni  (rst_ni),
    .push_i  (w_push),
    .pop_i   (w_pop),
    .wdata_i (w_wentry),
    .rdata_o (w_head),
    .full_o  (w_full),
    .empty_o (w_empty),
    .count_o (w_count)
  );

  always_comb begin
    w_disp_lane = '0;
    for (int i = N_LANES - 1; i >= 0; i--) begin
      if (w_is_idle[LANE_W'(i)]) w_disp_lane = LANE_W'(i);
    end
  end

  for (genvar gi = 0; gi < N_LANES; gi++) begin : g_lane
    lane_state_e      r_state;
    lane_state_e      w_state_n;
    logic [LAT_W-1:0] r_cnt;
    logic [LAT_W-1:0] w_cnt_n;
    logic [JOB_W-1:0] r_job;
    logic [JOB_W-1:0] w_job_n;
    logic             w_disp_hit;
    logic             w_acc_hit;

    assign w_disp_hit = w_pop & (w_disp_lane == LANE_W'(gi));
    assign w_acc_hit  = w_accept & (w_sel == LANE_W'(gi));

    always_ff @(posedge clk_i) begin
      if (!rst_ni) begin
        r_state <= IDLE;
        r_cnt   <= '0;
        r_job   <= '0;
      end else begin
        r_state <= w_state_n;
        r_cnt   <= w_cnt_n;
        r_job   <= w_job_n;
      end
    end

    always_comb begin
      w_state_n = r_state;
      w_cnt_n   = r_cnt;
      w_job_n   = r_job;
      case (r_state)
        IDLE: begin
          if (w_disp_hit) begin
            w_state_n = BUSY;
            w_cnt_n   = (w_head.lat == '0) ? LAT_W'(1) : w_head.lat;
            w_job_n   = w_head.job;
          end
        end
        BUSY: begin
          // The count parks at 1 on the way to DONE so it never reaches 0.
          if (r_cnt == LAT_W'(1)) w_state_n = DONE;
          else                    w_cnt_n   = r_cnt - LAT_W'(1);
        end
        DONE: begin
          if (w_acc_hit) w_state_n = IDLE;
        end
        default: w_state_n = IDLE;
      endcase
    end

    assign w_is_idle[gi]  = (r_state == IDLE);
    assign w_is_done[gi]  = (r_state == DONE);
    assign w_lane_job[gi] = r_job;
  end

  always_comb begin
    w_rr_valid = 1'b0;
    w_rr_sel   = '0;
    for (int k = N_LANES - 1; k >= 0; k--) begin
      if (w_is_done[LANE_W'((int'(r_ptr) + k) % N_LANES)]) begin
        w_rr_valid = 1'b1;
        w_rr_sel   = LANE_W'((int'(r_ptr) + k) % N_LANES);
      end
    end
  end

  // A stalled record stays locked so a later DONE lane cannot preempt it.
  assign w_valid  = r_locked | w_rr_valid;
  assign w_sel    = r_locked ? r_lock_lane : w_rr_sel;
  assign w_accept = w_valid & bus.done_ready_i;

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      r_ptr       <= '0;
      r_locked    <= 1'b0;
      r_lock_lane <= '0;
    end else begin
      r_locked    <= w_valid & ~bus.done_ready_i;
      r_lock_lane <= w_sel;
      if (w_accept) r_ptr <= LANE_W'((int'(w_sel) + 1) % N_LANES);
    end
  end

  assign bus.job_ready_o  = ~w_full;
  assign bus.done_valid_o = w_valid;
  assign bus.done_job_o   = w_valid ? w_lane_job[w_sel] : '0;
  assign bus.done_lane_o  = w_valid ? w_sel : '0;
  assign bus.lane_busy_o  = ~w_is_idle;
  assign bus.busy_o       = ~w_empty | ~(&w_is_idle);
  assign bus.fifo_count_o = w_count;

endmodule
`default_nettype wire

// File: tb/tb_consumer_pool.sv
`default_nettype none
// ============================================================================
// Module      : tb_consumer_pool
// Description : Directed scenarios plus randomized traffic against a queue model.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_consumer_pool;
  import vecunit_pkg::*;

  localparam int N     = 2;
  localparam int DEPTH = 4;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  int   n_cmp = 0;
  int   n_fail = 0;

  consumer_pool_if bus ();

  consumer_pool dut (
    .clk_i  (clk),
    .rst_ni (rst_n),
    .bus    (bus.slave)
  );

  always #5 clk = ~clk;

  // Transaction-level reference: a job queue, per-lane remaining service
  // cycles, the arbiter pointer and the currently presented lane.
  job_entry_t  m_q[$];
  int          m_rem [N];
  bit          m_has [N];
  logic [5:0]  m_job [N];
  int          m_ptr;
  int          m_pres;

  function automatic void model_reset();
    m_q.delete();
    for (int i = 0; i < N; i++) begin
      m_rem[i] = 0;
      m_has[i] = 1'b0;
      m_job[i] = '0;
    end
    m_ptr  = 0;
    m_pres = -1;
  endfunction

  function automatic void model_eval(output bit v, output int sel);
    v   = 1'b0;
    sel = 0;
    if (m_pres >= 0) begin
      v   = 1'b1;
      sel = m_pres;
    end else begin
      for (int k = 0; k < N; k++) begin
        if (!v && m_has[(m_ptr + k) % N] && m_rem[(m_ptr + k) % N] == 0) begin
          v   = 1'b1;
          sel = (m_ptr + k) % N;
        end
      end
    end
  endfunction

  function automatic void model_step(bit jv, logic [5:0] j, logic [3:0] l, bit dr);
    bit         v;
    int         sel;
    int         dl;
    bit         rdy;
    job_entry_t e;
    model_eval(v, sel);
    rdy = (m_q.size() < DEPTH);
    dl  = -1;
    if (m_q.size() > 0) begin
      for (int i = N - 1; i >= 0; i--) if (!m_has[i]) dl = i;
    end
    for (int i = 0; i < N; i++) if (m_has[i] && m_rem[i] > 0) m_rem[i]--;
    if (v && dr) begin
      m_has[sel] = 1'b0;
      m_ptr      = (sel + 1) % N;
    end
    m_pres = (v && !dr) ? sel : -1;
    if (dl >= 0) begin
      e         = m_q.pop_front();
      m_has[dl] = 1'b1;
      m_rem[dl] = (e.lat == 0) ? 1 : int'(e.lat);
      m_job[dl] = e.job;
    end
    if (jv && rdy) m_q.push_back('{job: j, lat: l});
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive_idle();
    bus.job_valid_i = 1'b0;
    bus.job_i       = '0;
    bus.lat_i       = '0;
  endtask

  task automatic apply_reset();
    rst_n = 1'b0;
    drive_idle();
    bus.done_ready_i = 1'b0;
    tick();
    rst_n = 1'b1;
  endtask

  task automatic test_reset();
    logic [14:0] got;
    apply_reset();
    @(negedge clk);
    got = {bus.done_valid_o, bus.done_job_o, bus.done_lane_o, bus.busy_o,
           bus.lane_busy_o, bus.fifo_count_o, bus.job_ready_o};
    n_cmp++;
    if (got !== 15'h0001) begin
      n_fail++;
      $display("FAIL reset_outputs got=%h exp=%h", got, 15'h0001);
    end
  endtask

  task automatic test_single();
    apply_reset();
    bus.done_ready_i = 1'b1;
    bus.job_valid_i = 1'b1; bus.job_i = 6'h2A; bus.lat_i = 4'd3;
    tick();
    drive_idle();
    for (int k = 0; k <= 6; k++) begin
      @(negedge clk);
      n_cmp++;
      if (bus.done_valid_o !== (k == 4)) begin
        n_fail++;
        $display("FAIL single_valid edge=%0d got=%b exp=%b", k, bus.done_valid_o, (k == 4));
      end
      if (k == 4) begin
        n_cmp++;
        if ({bus.done_job_o, bus.done_lane_o} !== {6'h2A, 1'b0}) begin
          n_fail++;
          $display("FAIL single_record got=%h/%0d exp=2a/0", bus.done_job_o, bus.done_lane_o);
        end
      end
      tick();
    end
    n_cmp++;
    if (bus.busy_o !== 1'b0) begin
      n_fail++;
      $display("FAIL single_busy_after got=%b exp=0", bus.busy_o);
    end
  endtask

  task automatic test_lat0();
    apply_reset();
    bus.done_ready_i = 1'b1;
    bus.job_valid_i = 1'b1; bus.job_i = 6'h00; bus.lat_i = 4'd0;
    tick();
    drive_idle();
    for (int k = 0; k <= 4; k++) begin
      @(negedge clk);
      n_cmp++;
      if (bus.done_valid_o !== (k == 2)) begin
        n_fail++;
        $display("FAIL lat0_valid edge=%0d got=%b exp=%b", k, bus.done_valid_o, (k == 2));
      end
      if (k == 2) begin
        n_cmp++;
        if ({bus.done_job_o, bus.done_lane_o} !== {6'h00, 1'b0}) begin
          n_fail++;
          $display("FAIL lat0_record got=%h/%0d exp=00/0", bus.done_job_o, bus.done_lane_o);
        end
      end
      tick();
    end
  endtask

  task automatic test_parallel();
    apply_reset();
    bus.done_ready_i = 1'b1;
    bus.job_valid_i = 1'b1; bus.job_i = 6'h11; bus.lat_i = 4'd5;
    tick();
    bus.job_i = 6'h22; bus.lat_i = 4'd1;
    tick();
    drive_idle();
    for (int k = 1; k <= 7; k++) begin
      @(negedge clk);
      n_cmp++;
      if (bus.done_valid_o !== (k == 3 || k == 6)) begin
        n_fail++;
        $display("FAIL par_valid edge=%0d got=%b exp=%b", k, bus.done_valid_o, (k == 3 || k == 6));
      end
      if (k == 2) begin
        n_cmp++;
        if (bus.lane_busy_o !== 2'b11) begin
          n_fail++;
          $display("FAIL par_lane_busy got=%b exp=11", bus.lane_busy_o);
        end
      end
      if (k == 3) begin
        n_cmp++;
        if ({bus.done_job_o, bus.done_lane_o} !== {6'h22, 1'b1}) begin
          n_fail++;
          $display("FAIL par_first got=%h/%0d exp=22/1", bus.done_job_o, bus.done_lane_o);
        end
      end
      if (k == 6) begin
        n_cmp++;
        if ({bus.done_job_o, bus.done_lane_o} !== {6'h11, 1'b0}) begin
          n_fail++;
          $display("FAIL par_second got=%h/%0d exp=11/0", bus.done_job_o, bus.done_lane_o);
        end
      end
      tick();
    end
  endtask

  task automatic test_backpressure();
    int         got;
    bit         extra;
    logic [5:0] ej;
    apply_reset();
    for (int i = 0; i < 6; i++) begin
      bus.job_valid_i = 1'b1; bus.job_i = 6'(48 + i); bus.lat_i = 4'd2;
      @(negedge clk);
      n_cmp++;
      if (bus.job_ready_o !== 1'b1) begin
        n_fail++;
        $display("FAIL bp_ready_fill job=%0d got=%b exp=1", i, bus.job_ready_o);
      end
      tick();
    end
    bus.job_i = 6'h3F; bus.lat_i = 4'd1;
    @(negedge clk);
    n_cmp++;
    if ({bus.job_ready_o, bus.fifo_count_o, bus.lane_busy_o, bus.done_valid_o} !== {1'b0, 3'd4, 2'b11, 1'b1}) begin
      n_fail++;
      $display("FAIL bp_full got=rdy%b cnt%0d lb%b v%b exp=rdy0 cnt4 lb11 v1",
               bus.job_ready_o, bus.fifo_count_o, bus.lane_busy_o, bus.done_valid_o);
    end
    tick();
    tick();
    drive_idle();
    bus.done_ready_i = 1'b1;
    got = 0;
    for (int c = 0; c < 80 && got < 6; c++) begin
      @(negedge clk);
      if (bus.done_valid_o === 1'b1) begin
        ej = 6'(48 + got);
        n_cmp++;
        if ({bus.done_job_o, bus.done_lane_o} !== {ej, 1'(got % 2)}) begin
          n_fail++;
          $display("FAIL bp_drain n=%0d got=%h/%0d exp=%h/%0d", got, bus.done_job_o,
                   bus.done_lane_o, ej, got % 2);
        end
        got++;
      end
      tick();
    end
    n_cmp++;
    if (got != 6) begin
      n_fail++;
      $display("FAIL bp_drain_count got=%0d exp=6", got);
    end
    extra = 1'b0;
    for (int c = 0; c < 10; c++) begin
      @(negedge clk);
      if (bus.done_valid_o !== 1'b0) extra = 1'b1;
      tick();
    end
    n_cmp++;
    if (extra || bus.busy_o !== 1'b0) begin
      n_fail++;
      $display("FAIL bp_no_extra got=extra%b busy%b exp=extra0 busy0", extra, bus.busy_o);
    end
  endtask

  task automatic test_stall();
    apply_reset();
    bus.job_valid_i = 1'b1; bus.job_i = 6'h05; bus.lat_i = 4'd8;
    tick();
    bus.job_i = 6'h06; bus.lat_i = 4'd1;
    tick();
    drive_idle();
    for (int k = 1; k <= 14; k++) begin
      @(negedge clk);
      if (k >= 3) begin
        n_cmp++;
        if ({bus.done_valid_o, bus.done_job_o, bus.done_lane_o} !== {1'b1, 6'h06, 1'b1}) begin
          n_fail++;
          $display("FAIL stall_hold edge=%0d got=%b/%h/%0d exp=1/06/1", k, bus.done_valid_o,
                   bus.done_job_o, bus.done_lane_o);
        end
      end
      if (k == 14) bus.done_ready_i = 1'b1;
      tick();
    end
    @(negedge clk);
    n_cmp++;
    if ({bus.done_valid_o, bus.done_job_o, bus.done_lane_o} !== {1'b1, 6'h05, 1'b0}) begin
      n_fail++;
      $display("FAIL stall_next got=%b/%h/%0d exp=1/05/0", bus.done_valid_o,
               bus.done_job_o, bus.done_lane_o);
    end
    tick();
  endtask

  task automatic test_reset_midrun();
    logic [14:0] got;
    bit          seen;
    apply_reset();
    for (int i = 0; i < 5; i++) begin
      bus.job_valid_i = 1'b1; bus.job_i = 6'(i + 1); bus.lat_i = 4'd15;
      tick();
    end
    drive_idle();
    @(negedge clk);
    n_cmp++;
    if ({bus.fifo_count_o, bus.lane_busy_o} !== {3'd3, 2'b11}) begin
      n_fail++;
      $display("FAIL midrun_loaded got=cnt%0d lb%b exp=cnt3 lb11", bus.fifo_count_o, bus.lane_busy_o);
    end
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    bus.done_ready_i = 1'b1;
    @(negedge clk);
    got = {bus.done_valid_o, bus.done_job_o, bus.done_lane_o, bus.busy_o,
           bus.lane_busy_o, bus.fifo_count_o, bus.job_ready_o};
    n_cmp++;
    if (got !== 15'h0001) begin
      n_fail++;
      $display("FAIL midrun_reset got=%h exp=%h", got, 15'h0001);
    end
    seen = 1'b0;
    for (int c = 0; c < 25; c++) begin
      tick();
      @(negedge clk);
      if (bus.done_valid_o !== 1'b0 || bus.busy_o !== 1'b0) seen = 1'b1;
    end
    n_cmp++;
    if (seen) begin
      n_fail++;
      $display("FAIL midrun_silent got=activity exp=none");
    end
    tick();
  endtask

  task automatic test_random();
    bit         ev;
    int         es;
    logic [5:0] ej;
    logic       el;
    logic [1:0] elb;
    bit         ebusy;
    apply_reset();
    model_reset();
    for (int cyc = 0; cyc < 600; cyc++) begin
      bus.job_valid_i  = ($urandom_range(0, 99) < 60);
      bus.job_i        = 6'($urandom_range(0, 63));
      bus.lat_i        = 4'($urandom_range(0, 6));
      bus.done_ready_i = ($urandom_range(0, 99) < 45);
      @(negedge clk);
      model_eval(ev, es);
      ej    = ev ? m_job[es] : 6'h00;
      el    = ev ? 1'(es) : 1'b0;
      elb   = {m_has[1], m_has[0]};
      ebusy = (m_q.size() > 0) || (elb != 2'b00);
      n_cmp++;
      if ({bus.done_valid_o, bus.done_job_o, bus.done_lane_o} !== {ev, ej, el}) begin
        n_fail++;
        $display("FAIL rnd_done cyc=%0d got=%b/%h/%0d exp=%b/%h/%0d", cyc, bus.done_valid_o,
                 bus.done_job_o, bus.done_lane_o, ev, ej, el);
      end
      n_cmp++;
      if ({bus.job_ready_o, bus.fifo_count_o} !== {(m_q.size() < DEPTH), 3'(m_q.size())}) begin
        n_fail++;
        $display("FAIL rnd_fifo cyc=%0d got=rdy%b cnt%0d exp=rdy%b cnt%0d", cyc, bus.job_ready_o,
                 bus.fifo_count_o, (m_q.size() < DEPTH), m_q.size());
      end
      n_cmp++;
      if ({bus.lane_busy_o, bus.busy_o} !== {elb, ebusy}) begin
        n_fail++;
        $display("FAIL rnd_busy cyc=%0d got=lb%b b%b exp=lb%b b%b", cyc, bus.lane_busy_o,
                 bus.busy_o, elb, ebusy);
      end
      @(posedge clk);
      model_step(bus.job_valid_i, bus.job_i, bus.lat_i, bus.done_ready_i);
      #1;
    end
    drive_idle();
    bus.done_ready_i = 1'b0;
  endtask

  initial begin
    test_reset();
    test_single();
    test_lat0();
    test_parallel();
    test_backpressure();
    test_stall();
    test_reset_midrun();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
